// File: rtl/ascon_init_core.sv
// Ascon-128 initialization engine: loads IV||K||N, runs p^12 one round per clock,
// then folds the key into x3/x4 and holds the result with end_o asserted.
//
// state | meaning
// IDLE  | waiting for start_i; state_o holds its last value
// ROUND | one permutation round per edge, cnt = round index 0..11
// DONE  | result valid, end_o=1; leaves only after start_i drops
module ascon_init_core #(
   parameter logic [63:0]  IV    = 64'h80400C0600000000,
   parameter logic [127:0] KEY   = 128'h000102030405060708090A0B0C0D0E0F,
   parameter logic [127:0] NONCE = 128'h000102030405060708090A0B0C0D0E0F
) (
   input  logic         clock_i,
   input  logic         resetb_i,
   input  logic         start_i,
   output logic         end_o,
   output logic [319:0] state_o
);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

   fsm_t          fsm_q, fsm_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [319:0]  state_q, state_d;
   logic [319:0]  round_out;
   logic          end_q;

   function automatic logic [4:0] sbox(input logic [4:0] v);
      logic [4:0] r;
      case (v)
         5'd0:  r = 5'h04;  5'd1:  r = 5'h0B;  5'd2:  r = 5'h1F;  5'd3:  r = 5'h14;
         5'd4:  r = 5'h1A;  5'd5:  r = 5'h15;  5'd6:  r = 5'h09;  5'd7:  r = 5'h02;
         5'd8:  r = 5'h1B;  5'd9:  r = 5'h05;  5'd10: r = 5'h08;  5'd11: r = 5'h12;
         5'd12: r = 5'h1D;  5'd13: r = 5'h03;  5'd14: r = 5'h06;  5'd15: r = 5'h1C;
         5'd16: r = 5'h1E;  5'd17: r = 5'h13;  5'd18: r = 5'h07;  5'd19: r = 5'h0E;
         5'd20: r = 5'h00;  5'd21: r = 5'h0D;  5'd22: r = 5'h11;  5'd23: r = 5'h18;
         5'd24: r = 5'h10;  5'd25: r = 5'h0C;  5'd26: r = 5'h01;  5'd27: r = 5'h19;
         5'd28: r = 5'h16;  5'd29: r = 5'h0A;  5'd30: r = 5'h0F;  default: r = 5'h17;
      endcase
      return r;
   endfunction

   function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   // One full round, combinational from the registered state and cnt_q
   always_comb begin
      logic [63:0] a0, a1, a2, a3, a4;
      logic [63:0] s0, s1, s2, s3, s4;
      logic [7:0]  rc;
      rc = 8'hF0 - ({4'h0, cnt_q} * 8'h0F);
      a0 = state_q[319:256];
      a1 = state_q[255:192];
      a2 = state_q[191:128] ^ {56'h0, rc};
      a3 = state_q[127:64];
      a4 = state_q[63:0];
      s0 = '0; s1 = '0; s2 = '0; s3 = '0; s4 = '0;
      for (int i = 0; i < 64; i++) begin
         {s0[i], s1[i], s2[i], s3[i], s4[i]} = sbox({a0[i], a1[i], a2[i], a3[i], a4[i]});
      end
      round_out = {s0 ^ rotr(s0, 19) ^ rotr(s0, 28),
                   s1 ^ rotr(s1, 61) ^ rotr(s1, 39),
                   s2 ^ rotr(s2, 1)  ^ rotr(s2, 6),
                   s3 ^ rotr(s3, 10) ^ rotr(s3, 17),
                   s4 ^ rotr(s4, 7)  ^ rotr(s4, 41)};
   end

   always_comb begin
      fsm_d   = fsm_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      case (fsm_q)
         IDLE: begin
            if (start_i) begin
               state_d = {IV, KEY, NONCE};
               cnt_d   = 4'd0;
               fsm_d   = ROUND;
            end
         end
         ROUND: begin
            state_d = round_out;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd11) begin
               state_d = round_out ^ {192'h0, KEY};
               cnt_d   = 4'd0;
               fsm_d   = DONE;
            end
         end
         DONE: begin
            if (!start_i) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (!resetb_i) begin
         fsm_q   <= IDLE;
         cnt_q   <= 4'd0;
         state_q <= '0;
         end_q   <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         end_q   <= (fsm_d == DONE);
      end
   end

   assign end_o   = end_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_ascon_init_core.sv
// Scoreboard bench for ascon_init_core: a bitsliced Ascon reference model pushes
// the expected {end_o, state_o} per cycle, popped and compared after each edge.
module tb_ascon_init_core;

   localparam logic [63:0]  IV    = 64'h80400C0600000000;
   localparam logic [127:0] KEY   = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] NONCE = 128'h000102030405060708090A0B0C0D0E0F;

   logic         clock_i;
   logic         resetb_i;
   logic         start_i;
   logic         end_o;
   logic [319:0] state_o;

   int checks   = 0;
   int failures = 0;
   logic [320:0] exp_q[$];
   logic [319:0] fin;

   ascon_init_core #(.IV(IV), .KEY(KEY), .NONCE(NONCE)) dut (
      .clock_i (clock_i),
      .resetb_i(resetb_i),
      .start_i (start_i),
      .end_o   (end_o),
      .state_o (state_o)
   );

   initial begin
      clock_i = 1'b0;
      forever #5 clock_i = ~clock_i;
   end

   task automatic check_val(input string tag, input logic [319:0] got, input logic [319:0] exp_v);
      checks++;
      if (got !== exp_v) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp_v);
      end
   endtask

   function automatic logic [63:0] m_rotr(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   // Reference round in the bitsliced form of the Ascon reference implementation
   function automatic logic [319:0] model_round(input logic [319:0] s, input int r);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      logic [7:0]  rc;
      rc = 8'(((15 - r) << 4) | r);
      x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
      x2 = x2 ^ {56'h0, rc};
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ m_rotr(x0, 19) ^ m_rotr(x0, 28);
      x1 = x1 ^ m_rotr(x1, 61) ^ m_rotr(x1, 39);
      x2 = x2 ^ m_rotr(x2, 1)  ^ m_rotr(x2, 6);
      x3 = x3 ^ m_rotr(x3, 10) ^ m_rotr(x3, 17);
      x4 = x4 ^ m_rotr(x4, 7)  ^ m_rotr(x4, 41);
      return {x0, x1, x2, x3, x4};
   endfunction

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   task automatic push_exp(input logic e, input logic [319:0] s);
      exp_q.push_back({e, s});
   endtask

   task automatic pop_check(input string tag);
      logic [320:0] v;
      if (exp_q.size() == 0) begin
         check_val({tag, "_empty"}, 320'd1, 320'd0);
      end else begin
         v = exp_q.pop_front();
         check_val({tag, "_end"},   {319'd0, end_o}, {319'd0, v[320]});
         check_val({tag, "_state"}, state_o, v[319:0]);
      end
   endtask

   // Start sampled at E0, then 12 round edges; glitch toggles start in cycles 3..8
   task automatic run_init(input string tag, input bit glitch, output logic [319:0] final_s);
      logic [319:0] s;
      s = {IV, KEY, NONCE};
      start_i = 1'b1;
      push_exp(1'b0, s);
      tick();
      pop_check({tag, "_load"});
      for (int r = 0; r < 12; r++) begin
         if (glitch && r >= 2 && r <= 7) start_i = ~start_i;
         else start_i = 1'b1;
         s = model_round(s, r);
         if (r == 11) s = s ^ {192'h0, KEY};
         push_exp(r == 11, s);
         tick();
         pop_check($sformatf("%s_r%0d", tag, r));
      end
      final_s = s;
   endtask

   initial begin
      resetb_i = 1'b0;
      start_i  = 1'b1;
      #2;
      push_exp(1'b0, '0);
      tick();
      push_exp(1'b0, '0);
      tick();
      pop_check("rst1");
      pop_check("rst2");
      resetb_i = 1'b1;
      start_i  = 1'b0;
      push_exp(1'b0, '0);
      tick();
      pop_check("idle");

      run_init("init", 1'b0, fin);
      for (int i = 0; i < 3; i++) begin
         push_exp(1'b1, fin);
         tick();
         pop_check($sformatf("hold%0d", i));
      end
      start_i = 1'b0;
      push_exp(1'b0, fin);
      tick();
      pop_check("drop");

      run_init("retrig", 1'b0, fin);
      start_i = 1'b0;
      tick();
      run_init("glitch", 1'b0 | 1'b1, fin);
      start_i = 1'b0;
      tick();

      start_i = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) tick();
      resetb_i = 1'b0;
      push_exp(1'b0, '0);
      tick();
      pop_check("midrst");
      resetb_i = 1'b1;
      start_i  = 1'b0;
      tick();
      run_init("after_rst", 1'b0, fin);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
